// File: rtl/hamm_pkg.sv
// Shared definitions for the Hamming error-injection stream: mode encodings,
// LFSR seed and feedback, and the default codeword width.
package hamm_pkg;
  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_WALK   = 2'b10;
  localparam logic [1:0] MODE_DOUBLE = 2'b11;

  localparam logic [7:0] LFSR_SEED    = 8'hA5;
  localparam int         DEF_CW_WIDTH = 7;

  // Fibonacci step for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
endpackage

// File: rtl/hamming_err_inject_stream_err_mask_gen.sv
// Combinational flip-mask generator: one bit at i_idx, plus its cyclic
// neighbour in double mode; empty when not a hit or the index is out of range.
module err_mask_gen
  import hamm_pkg::*;
#(
  parameter int CW_WIDTH = DEF_CW_WIDTH,
  parameter int IDX_W    = $clog2(CW_WIDTH)
) (
  input  logic [1:0]          i_mode,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_hit,
  output logic [CW_WIDTH-1:0] o_mask,
  output logic                o_in_range
);
  logic w_in_range;
  int   w_nxt;

  assign w_in_range = (int'(i_idx) < CW_WIDTH);
  assign o_in_range = w_in_range;
  assign w_nxt      = (int'(i_idx) == CW_WIDTH - 1) ? 0 : int'(i_idx) + 1;

  always_comb begin
    o_mask = '0;
    if (i_hit && w_in_range && (i_mode != MODE_PASS)) begin
      for (int b = 0; b < CW_WIDTH; b++) begin
        if ((b == int'(i_idx)) || ((i_mode == MODE_DOUBLE) && (b == w_nxt)))
          o_mask[b] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hamming_err_inject_stream.sv
// Streaming bit-flip injector between Hamming encoder and decoder; one output
// register, injects on every (cfg_period+1)th word. ERRINJ_LFSR_EN: random walk index.
module hamming_err_inject_stream
  import hamm_pkg::*;
#(
  parameter int CW_WIDTH = DEF_CW_WIDTH,
  parameter int IDX_W    = $clog2(CW_WIDTH),
  parameter int PERIOD_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cfg_mode,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                stat_clr,
  input  logic [CW_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CW_WIDTH-1:0] out_data,
  output logic [CW_WIDTH-1:0] out_mask,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    inj_count
);
  logic [PERIOD_W-1:0] r_sch;
  logic                w_acc;
  logic                w_hit;
  logic [IDX_W-1:0]    w_widx;
  logic [IDX_W-1:0]    w_idx;
  logic [CW_WIDTH-1:0] w_mask;
  logic                w_in_range;

  assign in_ready = ~out_valid | out_ready;
  assign w_acc    = in_valid & in_ready;
  assign w_hit    = (cfg_mode != MODE_PASS) && (r_sch == cfg_period);
  assign w_idx    = (cfg_mode == MODE_WALK) ? w_widx : cfg_idx;

`ifdef ERRINJ_LFSR_EN
  logic [7:0]       r_lfsr;
  logic [IDX_W-1:0] w_r;

  assign w_r    = r_lfsr[IDX_W-1:0];
  // Index field can exceed CW_WIDTH-1 by less than CW_WIDTH, so one subtract folds it
  assign w_widx = (int'(w_r) >= CW_WIDTH) ? IDX_W'(int'(w_r) - CW_WIDTH) : w_r;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) r_lfsr <= LFSR_SEED;
    else if (w_acc)      r_lfsr <= lfsr_step(r_lfsr);
  end
`else
  logic [IDX_W-1:0] r_widx;

  assign w_widx = r_widx;

  always_ff @(posedge clk) begin
    if (rst || stat_clr)
      r_widx <= '0;
    else if (w_acc && w_hit && (cfg_mode == MODE_WALK))
      r_widx <= (int'(r_widx) == CW_WIDTH - 1) ? '0 : r_widx + 1'b1;
  end
`endif

  err_mask_gen #(.CW_WIDTH(CW_WIDTH), .IDX_W(IDX_W)) u_mask (
    .i_mode     (cfg_mode),
    .i_idx      (w_idx),
    .i_hit      (w_hit),
    .o_mask     (w_mask),
    .o_in_range (w_in_range)
  );

  // Schedule counter; a clear in the same cycle as an accept wins
  always_ff @(posedge clk) begin
    if (rst || stat_clr)
      r_sch <= '0;
    else if (w_acc) begin
      if (cfg_mode == MODE_PASS || w_hit) r_sch <= '0;
      else                                r_sch <= r_sch + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr)
      inj_count <= '0;
    else if (w_acc && (|w_mask) && !(&inj_count))
      inj_count <= inj_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_mask  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_acc) begin
      out_data  <= in_data ^ w_mask;
      out_mask  <= w_mask;
      out_err   <= |w_mask;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/hamming_err_inject_stream.md
Name: hamming_err_inject_stream

Overview:
- Streaming, parametrised error injector for Hamming codewords; generalises the fixed 4-position bit-flip of the Hamming(7,4) lab.
- Sits between the Hamming encoder and decoder in the test path.
- Accepts codewords over a valid/ready handshake and flips zero, one or two bits on a programmable schedule (every Nth word).
- Registers each codeword with its flip mask so the downstream checker can score decoder correction.

Parameters:
- CW_WIDTH, 7, codeword width in bits (valid range 3..64).
- IDX_W, $clog2(CW_WIDTH), width of the bit-index fields.
- PERIOD_W, 8, width of the injection-period field.
- CNT_W, 16, width of the injection statistics counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  2  00 pass-through, 01 single fixed, 10 single walking, 11 double adjacent.
- cfg_idx  in  IDX_W  bit index for modes 01/11.
- cfg_period  in  PERIOD_W  inject on every (cfg_period+1)th accepted word.
- stat_clr  in  1  synchronous clear of the schedule counter, walking index and inj_count.
- in_data  in  CW_WIDTH  codeword from the encoder.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  CW_WIDTH  codeword after injection.
- out_mask  out  CW_WIDTH  bits flipped in out_data.
- out_err  out  1  out_mask is nonzero.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- inj_count  out  CNT_W  number of words injected; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a rising edge): out_data=0, out_mask=0, out_err=0, out_valid=0, inj_count=0, schedule counter sch=0, walking index widx=0. Reset mid-transfer drops the held word.
- Handshake and pipeline:
  - in_ready = ~out_valid | out_ready (combinational). A word is accepted when in_valid & in_ready.
  - Single output register; latency 1 cycle; back-to-back throughput 1 word/cycle.
  - out_valid is set on accept. It clears when out_ready=1 and no new accept occurs in that cycle.
  - While out_valid & ~out_ready, the output holds stable and nothing is accepted.
- Config sampling: cfg_* are sampled only at accept time. Changes between accepts take effect on the next accepted word.
- Schedule:
  - Mode 00: sch is forced to 0 and no bits are flipped.
  - Other modes, on accept: if sch==cfg_period the word is a hit and sch<=0; otherwise sch<=sch+1.
  - cfg_period=0 makes every word a hit.
  - If cfg_period is lowered below the current sch, the counter wraps through all-ones back to 0 before the next hit. This is accepted behaviour; do not special-case it.
- Mask on a hit:
  - Mode 01: mask = 1<<cfg_idx.
  - Mode 10: mask = 1<<widx; then widx advances, wrapping CW_WIDTH-1 -> 0.
  - Mode 11: mask = (1<<cfg_idx) | (1<<j), where j = cfg_idx+1, or 0 if cfg_idx==CW_WIDTH-1.
  - Non-hit: mask = 0.
- Out-of-range index: if cfg_idx >= CW_WIDTH in mode 01/11, mask=0. The hit still resets sch but is not counted.
- Output on accept: out_data <= in_data ^ mask, out_mask <= mask, out_err <= |mask.
- inj_count increments on each accept with nonzero mask and saturates at all-ones.
- stat_clr:
  - Clears sch, widx and inj_count. It does not touch the data path or out_valid.
  - If stat_clr and an accept occur in the same cycle, the clear wins for the counters. The accepted word still uses the pre-clear sch/widx to compute its mask.

Optional Feature:
- Macro: ERRINJ_LFSR_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst and on stat_clr.
  - The LFSR steps on every accept.
  - Mode 10 uses r = lfsr[IDX_W-1:0] instead of widx; if r >= CW_WIDTH, index = r-CW_WIDTH.
  - widx is removed.
- Undefined: mode 10 walks deterministically as described; no LFSR logic is synthesised.

Decomposition:
- Shared package hamm_pkg holds:
  - mode encodings MODE_PASS=2'b00, MODE_FIXED=2'b01, MODE_WALK=2'b10, MODE_DOUBLE=2'b11;
  - LFSR_SEED=8'hA5;
  - default CW_WIDTH=7.
- One natural sub-module, err_mask_gen: purely combinational. Inputs: mode, idx, hit. Outputs: the CW_WIDTH mask plus an in-range flag.

Test Plan:
- Pass-through: mode 00, out_ready=1, stream 0x00..0x7F -> out_data equals in_data one cycle later, out_mask=0, inj_count=0.
- Fixed every 3rd word: mode 01, idx=2, period=2, 6 words of 0x00 -> out_data 0,0,0x04,0,0,0x04; inj_count=2.
- Walking: mode 10, period=0, 8 words of 0x7F -> out_data 0x7E,0x7D,0x7B,0x77,0x6F,0x5F,0x3F,0x7E (wrap), out_err=1 each.
- Double with wrap: mode 11, idx=6, period=0, in 0x00 -> out_data=0x41, out_mask=0x41. Then idx=7 (out of range) -> mask 0, inj_count unchanged.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, sch unchanged. Release -> one word per cycle, no loss or duplication.
- Reset mid-stream: assert rst while out_valid=1 -> next cycle out_valid=0, inj_count=0. The first hit after reset occurs at word index cfg_period.
